// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing the LED[7:6] field between requesters A and B.
// Grants last at least MIN_HOLD cycles; a waiting requester preempts after MAX_HOLD.
module led_share_arbiter #(
    parameter int NBITS_DATA = 2,
    parameter int MIN_HOLD   = 2,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic [NBITS_DATA-1:0] data_a,
    input  logic [NBITS_DATA-1:0] data_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic [NBITS_DATA-1:0] out_data,
    output logic                  out_valid,
    output logic [7:0]            preempt_cnt
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_HOLD);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_b_q, last_b_d;      // 1: B was the most recent owner
    logic [7:0]    preempt_q, preempt_d;

    logic   own_req;
    logic   other_req;
    state_t other_state;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            preempt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_b_q  <= last_b_d;
            preempt_q <= preempt_d;
        end
    end

    // Requests seen from the current owner's point of view.
    always_comb begin
        own_req     = 1'b0;
        other_req   = 1'b0;
        other_state = IDLE;
        if (state_q == GRANT_A) begin
            own_req     = req_a;
            other_req   = req_b;
            other_state = GRANT_B;
        end else if (state_q == GRANT_B) begin
            own_req     = req_b;
            other_req   = req_a;
            other_state = GRANT_A;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_b_d  = last_b_q;
        preempt_d = preempt_q;
        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || last_b_q)) begin
                    state_d  = GRANT_A;
                    cnt_d    = ONE_C;
                    last_b_d = 1'b0;
                end else if (req_b) begin
                    state_d  = GRANT_B;
                    cnt_d    = ONE_C;
                    last_b_d = 1'b1;
                end
            end
            GRANT_A, GRANT_B: begin
                if (!own_req && cnt_q >= MIN_C) begin
                    if (other_req) begin
                        state_d  = other_state;
                        cnt_d    = ONE_C;
                        last_b_d = (other_state == GRANT_B);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (own_req && other_req && cnt_q >= MAX_C) begin
                    state_d  = other_state;
                    cnt_d    = ONE_C;
                    last_b_d = (other_state == GRANT_B);
                    if (preempt_q != 8'hFF) begin
                        preempt_d = preempt_q + 8'd1;
                    end
                end else if (cnt_q < MAX_C) begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_data = '0;
        case (state_q)
            GRANT_A: out_data = data_a;
            GRANT_B: out_data = data_b;
            default: out_data = '0;
        endcase
    end

    assign gnt_a       = (state_q == GRANT_A);
    assign gnt_b       = (state_q == GRANT_B);
    assign out_valid   = gnt_a | gnt_b;
    assign preempt_cnt = preempt_q;

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
Round-robin arbiter that shares the 2-bit LED output field (LED[7:6]) between two requesters, A and B. It replaces static switch-based selection with a request/grant handshake. Each grant lasts a guaranteed minimum time, and the holder is forcibly preempted after a maximum time if the other side is waiting. It sits between the board-level sources and the LED driver in top. It also exports a preemption count for LCD debug display.

Parameters:
NBITS_DATA, 2, width of each requester's data and of the shared output
MIN_HOLD, 2, minimum grant length in clk_2 cycles (>=1)
MAX_HOLD, 4, grant length after which a waiting requester forces preemption (>=MIN_HOLD)

Ports:
clk_2  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
req_a  input  1  requester A wants the output
req_b  input  1  requester B wants the output
data_a  input  NBITS_DATA  A's data
data_b  input  NBITS_DATA  B's data
gnt_a  output  1  A owns the output (registered)
gnt_b  output  1  B owns the output (registered)
out_data  output  NBITS_DATA  shared output, driven to LED[7:6]
out_valid  output  1  some requester owns the output
preempt_cnt  output  8  count of forced preemptions, saturating

Behaviour:
- States: IDLE, GRANT_A, GRANT_B. The state register, hold counter cnt ($clog2(MAX_HOLD+1) bits), last_owner flag and preempt_cnt are all flops.
- Reset (reset_n=0, asynchronous): state=IDLE, cnt=0, last_owner=B (so A wins the first tie), preempt_cnt=0. Outputs immediately go gnt_a=gnt_b=0, out_valid=0, out_data=0.
- Output decode: gnt_a=(state==GRANT_A); gnt_b=(state==GRANT_B); out_valid=gnt_a|gnt_b.
- out_data: combinational mux on the registered state. It is data_a in GRANT_A, data_b in GRANT_B, and 0 in IDLE.
- IDLE transitions:
  - Only req_a -> GRANT_A. Only req_b -> GRANT_B. Neither -> stay IDLE.
  - Both -> grant the requester that is not last_owner.
  - On entering any grant: cnt=1, and last_owner updates to the new owner.
- Latency: a request sampled in IDLE gives a grant asserted on the next cycle.
- In GRANT_X: cnt increments each cycle and saturates at MAX_HOLD.
- Voluntary release: !req_X && cnt>=MIN_HOLD.
  - If the other side is requesting -> go directly to GRANT_other, cnt=1, with no idle bubble.
  - Otherwise -> IDLE, cnt=0.
- Forced preemption: req_X && req_other && cnt>=MAX_HOLD -> GRANT_other, cnt=1, preempt_cnt+1 (saturates at 255).
- Request dropped before MIN_HOLD: the grant is held anyway. out_data keeps showing the owner's current data.
- Owner still requesting with no competitor: the grant is held indefinitely. cnt stays at MAX_HOLD and there is no preemption.
- Simultaneous voluntary release and eligible preemption cannot both be true. Release requires !req_X, preemption requires req_X.
- Reset asserted mid-grant: the grant drops immediately (asynchronously). After reset_n rises, arbitration restarts from IDLE with A favoured.
- gnt_a and gnt_b are never both 1 in any cycle.

Test Plan:
- Reset: hold reset_n=0 with req_a=req_b=1 -> gnt_a=gnt_b=0, out_data=0, preempt_cnt=0. Release reset at cycle 0 -> gnt_a=1 at cycle 1.
- Single short request: req_a pulsed for 1 cycle, data_a=2'b10 -> gnt_a high for exactly 2 cycles (MIN_HOLD) with out_data=2'b10, then IDLE with out_data=0.
- Tie after reset: req_a=req_b=1 in the same cycle -> gnt_a first. Later A drops at cnt=3 while B waits -> gnt_b on the next cycle with no IDLE gap, and preempt_cnt stays 0.
- Continuous contention: req_a=req_b=1 held for 20 cycles -> grants alternate in 4-cycle slots A,B,A,B,A. preempt_cnt increments at each switch, reaching 4.
- Data mux: data_a=2'b10, data_b=2'b01 during alternation -> out_data tracks the owner every cycle. Change data_a mid-grant -> out_data changes in the same cycle.
- Async reset mid-grant: drop reset_n in cycle 2 of GRANT_B, between clock edges -> gnt_b=0 before the next edge. After release with both requesting -> A is granted first.
